sfx_event_arbiter: RTL and testbench
====================================

Name: sfx_event_arbiter

Overview:
Upstream feeder for the audio processing unit. It turns the three raw, asynchronous collision pins (sheep/dragon, sword/dragon, player/dragon) into clean, prioritised, frame-timed sound-effect commands. It synchronises and edge-detects each pin, latches pending events, and arbitrates by priority. It holds one active effect ID for a programmed number of video frames, with an optional silent gap between effects. The APU consumes sfx_id, sfx_active and sfx_start instead of level-sensitive collision wires.

Parameters:
- SHEEP_FRAMES, 8, effect duration in frames for sheep/dragon (1..2^CNT_W-1)
- SWORD_FRAMES, 12, effect duration in frames for sword/dragon
- PLAYER_FRAMES, 30, effect duration in frames for player/dragon
- GAP_FRAMES, 2, silent frames after an effect ends (0 allowed)
- CNT_W, 6, width of the frame down-counter

Ports:
- clk  in  1  system clock (pixel clock domain)
- reset  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per frame, generated from the sync generator at hpos==0, vpos==0
- sheep_dragon_collision  in  1  raw async pin
- sword_dragon_collision  in  1  raw async pin
- player_dragon_collision  in  1  raw async pin
- sfx_id  out  2  0=none, 1=sheep, 2=sword, 3=player
- sfx_active  out  1  high while an effect plays
- sfx_start  out  1  one-cycle pulse on every effect start, including preemption
- pending  out  3  {player, sword, sheep} latched-but-unserved events (debug)

Behaviour:
- Reset: one clk, reset, and all state synchronous active-high, as already decided. All outputs are 0; FSM goes to IDLE; counter, pending bits and sync/edge flops are 0.
- Sync: two-flop synchroniser per pin. A rising edge is sync[1]&~prev. Level-high inputs produce one event only. An input held high through reset produces exactly one event after reset.
- Pending: bit set on edge and cleared when its effect starts. Set wins over clear in the same cycle.
- Latency: pin rises before clk edge k. Pending is visible after edge k+2. sfx_start, sfx_id and sfx_active are asserted after edge k+3 if the FSM is IDLE.
- Priority: player > sword > sheep.
- FSM IDLE:
  - If any pending, select the highest-priority one.
  - Register sfx_id, assert sfx_active and pulse sfx_start.
  - Load the counter with that ID's FRAMES value and go to PLAY.
- FSM PLAY:
  - Each frame_tick decrements the counter.
  - The tick that takes the counter 1->0 moves the FSM to GAP, or to IDLE if GAP_FRAMES==0. sfx_active and sfx_id drop to 0 on that same edge.
  - A frame_tick in the start cycle is ignored, so PLAY spans exactly N ticks.
- FSM GAP:
  - Load GAP_FRAMES on entry and decrement on frame_tick; go to IDLE at 0. Outputs stay 0.
  - Pending events accumulate during GAP and are served in IDLE.
- Same-ID retrigger while playing: the pending bit is set and served after the current effect and gap. There is no restart.
- Counter arithmetic: unsigned CNT_W bits; never decrements below 0; no wrap.
- Reset mid-PLAY: immediate return to IDLE with outputs 0; pending events are lost.

Optional Feature:
Macro: SFX_PREEMPT_EN.
- Defined: in PLAY, a pending event of strictly higher priority than the current sfx_id preempts on the next edge.
  - sfx_start pulses and sfx_id changes.
  - The counter reloads with the new duration and the gap is skipped.
  - The preempted effect is not resumed.
- Undefined: effects always play to completion; higher-priority events wait in pending.

Decomposition:
- Shared package sfx_pkg:
  - SFX_NONE/SHEEP/SWORD/PLAYER 2-bit ID constants
  - state enum IDLE/PLAY/GAP
  - default duration constants, also used by the APU to size its effect tables
- One natural sub-module: sfx_edge_sync. It holds the two-flop synchroniser plus rising-edge detector and is instantiated three times.

Test Plan:
- Reset release with inputs low -> all outputs 0. Raise sheep pin for 1 cycle -> sfx_start pulses 4 clks later; sfx_id=1, sfx_active=1 for exactly 8 frame_ticks, then 2 silent ticks, then IDLE.
- Raise sheep and player in the same cycle -> player (id 3) plays 30 ticks. After the 2-tick gap, sheep (id 1) starts; pending shows 3'b001 during player.
- Hold sword pin high for 100 frames -> exactly one sfx_start, id 2, 12 ticks; no second event.
- During sheep PLAY (tick 3) raise player. With SFX_PREEMPT_EN: sfx_start pulses, id->3, 30 ticks, no gap in between. Without it: sheep finishes its 8 ticks, gap, then player.
- Assert reset at PLAY tick 5 with sword pending -> the next cycle shows sfx_active=0, sfx_id=0, pending=0, FSM IDLE. After release, no event plays unless a new edge occurs.
- frame_tick coincident with sfx_start; GAP_FRAMES=0 build -> effect still lasts exactly its N ticks; next pending starts one cycle after the last tick.

Source files
------------

// File: rtl/sfx_pkg.sv
// Shared sound-effect IDs, FSM states and default durations for the collision
// arbiter and the APU effect tables.
package sfx_pkg;

    localparam logic [1:0] SFX_NONE   = 2'd0;
    localparam logic [1:0] SFX_SHEEP  = 2'd1;
    localparam logic [1:0] SFX_SWORD  = 2'd2;
    localparam logic [1:0] SFX_PLAYER = 2'd3;

    localparam int SHEEP_FRAMES_DEF  = 8;
    localparam int SWORD_FRAMES_DEF  = 12;
    localparam int PLAYER_FRAMES_DEF = 30;
    localparam int GAP_FRAMES_DEF    = 2;
    localparam int CNT_W_DEF         = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } sfx_state_t;

    // Pending bits are {player, sword, sheep}; player wins, sheep loses.
    function automatic logic [1:0] sfx_select(input logic [2:0] pend);
        if (pend[2])      return SFX_PLAYER;
        else if (pend[1]) return SFX_SWORD;
        else if (pend[0]) return SFX_SHEEP;
        else              return SFX_NONE;
    endfunction

endpackage

// File: rtl/sfx_edge_sync.sv
// Two-flop synchroniser for one raw collision pin followed by a rising-edge
// detector; a level held high yields a single one-cycle rise pulse.
module sfx_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic pin_async,
    output logic rise
);

    logic [1:0] sync_q, sync_d;
    logic       prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[0], pin_async};
        prev_d = sync_q[1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 2'b00;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise = sync_q[1] & ~prev_q;

endmodule

// File: rtl/sfx_event_arbiter.sv
// Collision-to-sound-effect arbiter: latches pin edges, picks the highest
// priority event and holds it for N frames plus a silent gap.
// Define SFX_PREEMPT_EN to let a higher-priority event cut a playing effect.
module sfx_event_arbiter
    import sfx_pkg::*;
#(
    parameter int SHEEP_FRAMES  = SHEEP_FRAMES_DEF,
    parameter int SWORD_FRAMES  = SWORD_FRAMES_DEF,
    parameter int PLAYER_FRAMES = PLAYER_FRAMES_DEF,
    parameter int GAP_FRAMES    = GAP_FRAMES_DEF,
    parameter int CNT_W         = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       sheep_dragon_collision,
    input  logic       sword_dragon_collision,
    input  logic       player_dragon_collision,
    output logic [1:0] sfx_id,
    output logic       sfx_active,
    output logic       sfx_start,
    output logic [2:0] pending
);

    logic [2:0] pins;
    logic [2:0] rise;

    assign pins = {player_dragon_collision, sword_dragon_collision, sheep_dragon_collision};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            sfx_edge_sync u_sync (
                .clk       (clk),
                .reset     (reset),
                .pin_async (pins[gi]),
                .rise      (rise[gi])
            );
        end
    endgenerate

    sfx_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       id_q, id_d;
    logic             active_q, active_d;
    logic             start_q, start_d;
    logic [2:0]       pending_q, pending_d;

    logic [1:0]       best;
    logic             launch;
    logic             preempt;
    logic [2:0]       clr;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        id_d     = id_q;
        active_d = active_q;
        start_d  = 1'b0;
        clr      = 3'b000;
        launch   = 1'b0;
        preempt  = 1'b0;
        best     = sfx_select(pending_q);

        case (state_q)
            ST_IDLE: begin
                launch = (best != SFX_NONE);
            end
            ST_PLAY: begin
`ifdef SFX_PREEMPT_EN
                preempt = (best > id_q);
`else
                preempt = 1'b0;
`endif
                if (preempt) begin
                    launch = 1'b1;
                // The tick landing in the start cycle is ignored so PLAY spans exactly N ticks.
                end else if (frame_tick && !start_q) begin
                    if (cnt_q > CNT_W'(1)) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        id_d     = SFX_NONE;
                        active_d = 1'b0;
                        if (GAP_FRAMES == 0) begin
                            cnt_d   = '0;
                            state_d = ST_IDLE;
                        end else begin
                            cnt_d   = CNT_W'(GAP_FRAMES);
                            state_d = ST_GAP;
                        end
                    end
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else if (frame_tick) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (launch) begin
            id_d     = best;
            active_d = 1'b1;
            start_d  = 1'b1;
            state_d  = ST_PLAY;
            case (best)
                SFX_SHEEP:  begin cnt_d = CNT_W'(SHEEP_FRAMES);  clr = 3'b001; end
                SFX_SWORD:  begin cnt_d = CNT_W'(SWORD_FRAMES);  clr = 3'b010; end
                SFX_PLAYER: begin cnt_d = CNT_W'(PLAYER_FRAMES); clr = 3'b100; end
                default:    begin cnt_d = '0;                    clr = 3'b000; end
            endcase
        end

        // A fresh edge in the same cycle as the serve keeps the bit set.
        pending_d = (pending_q & ~clr) | rise;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            id_q      <= SFX_NONE;
            active_q  <= 1'b0;
            start_q   <= 1'b0;
            pending_q <= 3'b000;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            id_q      <= id_d;
            active_q  <= active_d;
            start_q   <= start_d;
            pending_q <= pending_d;
        end
    end

    assign sfx_id     = id_q;
    assign sfx_active = active_q;
    assign sfx_start  = start_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_sfx_event_arbiter.sv
// Directed bench for sfx_event_arbiter: default build plus a GAP_FRAMES=0 copy
// driven by the same pins.
module tb_sfx_event_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic [2:0] pin_vec = 3'b000;

    logic [1:0] sfx_id, sfx_id0;
    logic       sfx_active, sfx_active0;
    logic       sfx_start, sfx_start0;
    logic [2:0] pending, pending0;

    int tests_run = 0;
    int tests_failed = 0;
    int n_starts;

    always #5 clk = ~clk;

    sfx_event_arbiter dut (
        .clk                     (clk),
        .reset                   (reset),
        .frame_tick              (frame_tick),
        .sheep_dragon_collision  (pin_vec[0]),
        .sword_dragon_collision  (pin_vec[1]),
        .player_dragon_collision (pin_vec[2]),
        .sfx_id                  (sfx_id),
        .sfx_active              (sfx_active),
        .sfx_start               (sfx_start),
        .pending                 (pending)
    );

    sfx_event_arbiter #(.GAP_FRAMES(0)) dut0 (
        .clk                     (clk),
        .reset                   (reset),
        .frame_tick              (frame_tick),
        .sheep_dragon_collision  (pin_vec[0]),
        .sword_dragon_collision  (pin_vec[1]),
        .player_dragon_collision (pin_vec[2]),
        .sfx_id                  (sfx_id0),
        .sfx_active              (sfx_active0),
        .sfx_start               (sfx_start0),
        .pending                 (pending0)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
        end
    endtask

    task automatic pulse_pin(input logic [2:0] m);
        pin_vec = m;
        step();
        pin_vec = 3'b000;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        tests_run++;
        if ({sfx_id, sfx_active, sfx_start, pending} !== 7'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b expected 0000000", {sfx_id, sfx_active, sfx_start, pending});
        end
        tests_run++;
        if ({sfx_id0, sfx_active0, sfx_start0, pending0} !== 7'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs_gap0: got %b expected 0000000", {sfx_id0, sfx_active0, sfx_start0, pending0});
        end
        $display("[TB] reset: id=%0d active=%0b start=%0b pending=%b", sfx_id, sfx_active, sfx_start, pending);
    endtask

    task automatic test_single_sheep();
        pulse_pin(3'b001);
        step();
        step();
        tests_run++;
        if ({pending, sfx_start} !== 4'b0010) begin
            tests_failed++;
            $display("FAIL sheep_pending_latency: got pending=%b start=%b expected 001/0", pending, sfx_start);
        end
        step();
        tests_run++;
        if ({sfx_start, sfx_active, sfx_id, pending} !== 7'b11_01_000) begin
            tests_failed++;
            $display("FAIL sheep_start: got %b expected 1101000", {sfx_start, sfx_active, sfx_id, pending});
        end
        step();
        tests_run++;
        if (sfx_start !== 1'b0) begin
            tests_failed++;
            $display("FAIL sheep_start_pulse_width: got %b expected 0", sfx_start);
        end
        ticks(7);
        tests_run++;
        if ({sfx_active, sfx_id} !== 3'b101) begin
            tests_failed++;
            $display("FAIL sheep_tick7: got %b expected 101", {sfx_active, sfx_id});
        end
        ticks(1);
        tests_run++;
        if ({sfx_active, sfx_id} !== 3'b000) begin
            tests_failed++;
            $display("FAIL sheep_tick8_end: got %b expected 000", {sfx_active, sfx_id});
        end
        pulse_pin(3'b001);
        step();
        step();
        tests_run++;
        if ({pending, sfx_start} !== 4'b0010) begin
            tests_failed++;
            $display("FAIL gap_pending_held: got pending=%b start=%b expected 001/0", pending, sfx_start);
        end
        ticks(1);
        step();
        tests_run++;
        if ({sfx_start, sfx_active} !== 2'b00) begin
            tests_failed++;
            $display("FAIL gap_tick1_silent: got %b expected 00", {sfx_start, sfx_active});
        end
        ticks(1);
        tests_run++;
        if (sfx_start !== 1'b0) begin
            tests_failed++;
            $display("FAIL gap_tick2_silent: got %b expected 0", sfx_start);
        end
        step();
        tests_run++;
        if ({sfx_start, sfx_id} !== 3'b101) begin
            tests_failed++;
            $display("FAIL after_gap_start: got %b expected 101", {sfx_start, sfx_id});
        end
        step();
        ticks(10);
        $display("[TB] single_sheep: done, active=%0b", sfx_active);
    endtask

    task automatic test_priority();
        pulse_pin(3'b101);
        step();
        step();
        tests_run++;
        if (pending !== 3'b101) begin
            tests_failed++;
            $display("FAIL prio_pending: got %b expected 101", pending);
        end
        step();
        tests_run++;
        if ({sfx_start, sfx_id, pending} !== 6'b1_11_001) begin
            tests_failed++;
            $display("FAIL prio_player_first: got %b expected 111001", {sfx_start, sfx_id, pending});
        end
        step();
        ticks(29);
        tests_run++;
        if ({sfx_active, sfx_id, pending} !== 6'b1_11_001) begin
            tests_failed++;
            $display("FAIL prio_player_tick29: got %b expected 111001", {sfx_active, sfx_id, pending});
        end
        ticks(1);
        tests_run++;
        if ({sfx_active, sfx_id} !== 3'b000) begin
            tests_failed++;
            $display("FAIL prio_player_end: got %b expected 000", {sfx_active, sfx_id});
        end
        ticks(2);
        step();
        tests_run++;
        if ({sfx_start, sfx_id, pending} !== 6'b1_01_000) begin
            tests_failed++;
            $display("FAIL prio_sheep_second: got %b expected 101000", {sfx_start, sfx_id, pending});
        end
        step();
        ticks(10);
        $display("[TB] priority: player then sheep served");
    endtask

    task automatic test_hold_sword();
        pin_vec = 3'b010;
        step();
        step();
        step();
        step();
        tests_run++;
        if ({sfx_start, sfx_id} !== 3'b110) begin
            tests_failed++;
            $display("FAIL hold_sword_start: got %b expected 110", {sfx_start, sfx_id});
        end
        step();
        ticks(11);
        tests_run++;
        if ({sfx_active, sfx_id} !== 3'b110) begin
            tests_failed++;
            $display("FAIL hold_sword_tick11: got %b expected 110", {sfx_active, sfx_id});
        end
        ticks(1);
        tests_run++;
        if ({sfx_active, sfx_id} !== 3'b000) begin
            tests_failed++;
            $display("FAIL hold_sword_end: got %b expected 000", {sfx_active, sfx_id});
        end
        n_starts = 0;
        for (int i = 0; i < 100; i++) begin
            ticks(1);
            if (sfx_start === 1'b1) n_starts++;
        end
        tests_run++;
        if (n_starts !== 0 || sfx_active !== 1'b0 || pending !== 3'b000) begin
            tests_failed++;
            $display("FAIL hold_sword_single_event: got starts=%0d active=%b pending=%b expected 0/0/000",
                     n_starts, sfx_active, pending);
        end
        pin_vec = 3'b000;
        step();
        step();
        step();
        $display("[TB] hold_sword: extra starts=%0d", n_starts);
    endtask

    task automatic test_preempt();
        pulse_pin(3'b001);
        step();
        step();
        step();
        step();
        ticks(3);
        pulse_pin(3'b100);
        step();
        step();
        tests_run++;
        if ({pending, sfx_id} !== 5'b100_01) begin
            tests_failed++;
            $display("FAIL preempt_pending: got %b expected 10001", {pending, sfx_id});
        end
        step();
`ifdef SFX_PREEMPT_EN
        tests_run++;
        if ({sfx_start, sfx_active, sfx_id, pending} !== 7'b1_1_11_000) begin
            tests_failed++;
            $display("FAIL preempt_switch: got %b expected 1111000", {sfx_start, sfx_active, sfx_id, pending});
        end
        step();
        ticks(29);
        tests_run++;
        if ({sfx_active, sfx_id} !== 3'b111) begin
            tests_failed++;
            $display("FAIL preempt_player_tick29: got %b expected 111", {sfx_active, sfx_id});
        end
        ticks(1);
        tests_run++;
        if ({sfx_active, sfx_id} !== 3'b000) begin
            tests_failed++;
            $display("FAIL preempt_player_end: got %b expected 000", {sfx_active, sfx_id});
        end
        ticks(2);
`else
        tests_run++;
        if ({sfx_start, sfx_id, pending} !== 6'b0_01_100) begin
            tests_failed++;
            $display("FAIL nopreempt_wait: got %b expected 001100", {sfx_start, sfx_id, pending});
        end
        ticks(4);
        tests_run++;
        if ({sfx_active, sfx_id} !== 3'b101) begin
            tests_failed++;
            $display("FAIL nopreempt_sheep_tick7: got %b expected 101", {sfx_active, sfx_id});
        end
        ticks(1);
        tests_run++;
        if ({sfx_active, sfx_id} !== 3'b000) begin
            tests_failed++;
            $display("FAIL nopreempt_sheep_end: got %b expected 000", {sfx_active, sfx_id});
        end
        ticks(2);
        step();
        tests_run++;
        if ({sfx_start, sfx_id, pending} !== 6'b1_11_000) begin
            tests_failed++;
            $display("FAIL nopreempt_player_after_gap: got %b expected 111000", {sfx_start, sfx_id, pending});
        end
        step();
        ticks(32);
`endif
        tests_run++;
        if (sfx_active !== 1'b0) begin
            tests_failed++;
            $display("FAIL preempt_final_idle: got %b expected 0", sfx_active);
        end
        $display("[TB] preempt: sequence complete");
    endtask

    task automatic test_reset_mid_play();
        pulse_pin(3'b010);
        step();
        step();
        step();
        step();
        ticks(5);
        pulse_pin(3'b010);
        step();
        step();
        tests_run++;
        if ({pending, sfx_active, sfx_id} !== 6'b010_1_10) begin
            tests_failed++;
            $display("FAIL midplay_setup: got %b expected 010110", {pending, sfx_active, sfx_id});
        end
        reset = 1'b1;
        step();
        tests_run++;
        if ({sfx_active, sfx_id, pending, sfx_start} !== 7'd0) begin
            tests_failed++;
            $display("FAIL midplay_reset_clear: got %b expected 0000000", {sfx_active, sfx_id, pending, sfx_start});
        end
        reset = 1'b0;
        n_starts = 0;
        for (int i = 0; i < 10; i++) begin
            ticks(1);
            if (sfx_active === 1'b1 || sfx_start === 1'b1) n_starts++;
        end
        tests_run++;
        if (n_starts !== 0) begin
            tests_failed++;
            $display("FAIL midplay_no_replay: got %0d active cycles expected 0", n_starts);
        end
        $display("[TB] reset_mid_play: active cycles after release=%0d", n_starts);
    endtask

    task automatic test_tick_coincident_gap0();
        pulse_pin(3'b001);
        step();
        step();
        step();
        tests_run++;
        if ({sfx_start, sfx_start0, sfx_id0} !== 4'b1101) begin
            tests_failed++;
            $display("FAIL coinc_start: got %b expected 1101", {sfx_start, sfx_start0, sfx_id0});
        end
        ticks(1);
        ticks(3);
        pulse_pin(3'b001);
        step();
        step();
        tests_run++;
        if ({pending, pending0, sfx_start, sfx_id} !== 9'b001_001_0_01) begin
            tests_failed++;
            $display("FAIL retrigger_no_restart: got %b expected 001001001", {pending, pending0, sfx_start, sfx_id});
        end
        ticks(4);
        tests_run++;
        if ({sfx_active, sfx_active0} !== 2'b11) begin
            tests_failed++;
            $display("FAIL coinc_tick7_active: got %b expected 11", {sfx_active, sfx_active0});
        end
        ticks(1);
        tests_run++;
        if ({sfx_active, sfx_active0} !== 2'b00) begin
            tests_failed++;
            $display("FAIL coinc_tick8_end: got %b expected 00", {sfx_active, sfx_active0});
        end
        step();
        tests_run++;
        if ({sfx_start0, sfx_id0, sfx_start} !== 4'b1010) begin
            tests_failed++;
            $display("FAIL gap0_next_start: got %b expected 1010", {sfx_start0, sfx_id0, sfx_start});
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        $display("[TB] tick_coincident_gap0: done");
    endtask

    initial begin
        test_reset();
        test_single_sheep();
        test_priority();
        test_hold_sword();
        test_preempt();
        test_reset_mid_play();
        test_tick_coincident_gap0();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
